// File: rtl/dmd_capture.sv
// ---------------------------------------------------------------------------
// dmd_capture
//
// Captures the serial dot stream of a pinball DMD controller (COLS x ROWS,
// 1 bit per dot) into a ping-pong frame buffer. The block drives the write
// port of a dual-port frame RAM; VideoGen reads the other bank on its own
// clock. A frame only becomes visible through a bank swap after every row
// arrived well formed; malformed frames are dropped.
//
// Ports:
//   clk          capture / RAM write clock (ram_clk)
//   rst_n        asynchronous active-low reset
//   dmd_dotclk   DMD dot clock, data valid on its rising edge
//   dmd_data     serial dot data, leftmost dot first
//   dmd_rowclk   row advance strobe (rising edge)
//   dmd_rowdata  first-row marker, sampled with the rowclk rising edge
//   dmd_latch    row latch, its rising edge ends the row
//   wr_en        RAM byte write strobe
//   wr_addr      {bank, row, byte_col}
//   wr_data      one byte of dots, bit7 = leftmost dot
//   rd_bank      bank VideoGen reads; writes always go to ~rd_bank
//   frame_done   one-cycle pulse on a successful bank swap
//   frame_err    one-cycle pulse when a frame is dropped
// ---------------------------------------------------------------------------
module dmd_capture #(
    parameter int COLS        = 128,
    parameter int ROWS        = 32,
    parameter int SYNC_STAGES = 2,
    localparam int CW         = $clog2(COLS / 8),
    localparam int RW         = $clog2(ROWS),
    localparam int AW         = 1 + RW + CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dmd_dotclk,
    input  logic          dmd_data,
    input  logic          dmd_rowclk,
    input  logic          dmd_rowdata,
    input  logic          dmd_latch,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          rd_bank,
    output logic          frame_done,
    output logic          frame_err
);

    // Column counter must be able to hold COLS itself (a complete row).
    localparam int CLW = CW + 4;
    localparam logic [CLW-1:0] COLS_L   = CLW'(COLS);
    localparam logic [RW-1:0]  LAST_ROW = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        WAIT_SYNC,
        SHIFT,
        COMMIT
    } state_t;

    state_t state_q, state_d;

    // Synchronizer chain, bit order {latch, rowdata, rowclk, data, dotclk}.
    logic [4:0] sync_q [SYNC_STAGES];
    logic [4:0] synced;
    logic [2:0] edgeDly_q;

    logic dotRise, rowRise, latchRise;
    logic dataS, rowDataS;
    logic lastRowLatch;

    logic [RW-1:0]  row_q, row_d;
    logic [CLW-1:0] col_q, col_d;
    // Only 7 bits are kept: the oldest bit of a byte leaves with the write.
    logic [6:0]     sr_q, sr_d;
    logic           rowBad_q, rowBad_d;
    logic           frameBad_q, frameBad_d;
    logic           rowOvf_q, rowOvf_d;
    logic           wrEn_q, wrEn_d;
    logic [AW-1:0]  wrAddr_q, wrAddr_d;
    logic [7:0]     wrData_q, wrData_d;
    logic           rdBank_q, rdBank_d;
    logic           frameDone_q, frameDone_d;
    logic           frameErr_q, frameErr_d;

    // Data and rowdata travel through the same depth as their strobes, so
    // they stay aligned with the detected edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            edgeDly_q <= '0;
        end else begin
            sync_q[0] <= {dmd_latch, dmd_rowdata, dmd_rowclk, dmd_data, dmd_dotclk};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            edgeDly_q <= {synced[4], synced[2], synced[0]};
        end
    end

    assign synced    = sync_q[SYNC_STAGES-1];
    assign dataS     = synced[1];
    assign rowDataS  = synced[3];
    assign dotRise   = synced[0] & ~edgeDly_q[0];
    assign rowRise   = synced[2] & ~edgeDly_q[1];
    assign latchRise = synced[4] & ~edgeDly_q[2];

    // A latch on the last row hands the frame to COMMIT; a rowclk edge in
    // that same cycle is not acted on.
    assign lastRowLatch = latchRise && (row_q == LAST_ROW);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_SYNC: if (rowRise && rowDataS) state_d = SHIFT;
            SHIFT:     if (lastRowLatch)        state_d = COMMIT;
            COMMIT:    state_d = WAIT_SYNC;
            default:   state_d = WAIT_SYNC;
        endcase
    end

    // Datapath and output logic. Within SHIFT the edges are handled in the
    // order dot, latch, rowclk; later steps see the results of earlier ones.
    always_comb begin
        row_d       = row_q;
        col_d       = col_q;
        sr_d        = sr_q;
        rowBad_d    = rowBad_q;
        frameBad_d  = frameBad_q;
        rowOvf_d    = rowOvf_q;
        wrEn_d      = 1'b0;
        wrAddr_d    = wrAddr_q;
        wrData_d    = wrData_q;
        rdBank_d    = rdBank_q;
        frameDone_d = 1'b0;
        frameErr_d  = 1'b0;

        case (state_q)
            WAIT_SYNC: begin
                if (rowRise && rowDataS) begin
                    row_d      = '0;
                    col_d      = '0;
                    frameBad_d = 1'b0;
                    rowBad_d   = 1'b0;
                    rowOvf_d   = 1'b0;
                end
            end

            SHIFT: begin
                if (dotRise) begin
                    if (col_q == COLS_L) begin
                        rowBad_d = 1'b1;
                    end else begin
                        sr_d  = {sr_q[5:0], dataS};
                        col_d = col_q + 1'b1;
                        // A clamped (overflowed) row never reaches the RAM.
                        if ((col_q[2:0] == 3'd7) && !rowOvf_q) begin
                            wrEn_d   = 1'b1;
                            wrData_d = {sr_q, dataS};
                            wrAddr_d = {~rdBank_q, row_q, col_q[CW+2:3]};
                        end
                    end
                end

                if (latchRise) begin
                    if (col_d != COLS_L) rowBad_d = 1'b1;
                    frameBad_d = frameBad_d | rowBad_d;
                    rowBad_d   = 1'b0;
                    col_d      = '0;
                end

                if (rowRise && !lastRowLatch) begin
                    if (rowDataS) begin
                        frameErr_d = 1'b1;
                        row_d      = '0;
                        frameBad_d = 1'b0;
                        rowOvf_d   = 1'b0;
                    end else if (row_q == LAST_ROW) begin
                        frameBad_d = 1'b1;
                        rowOvf_d   = 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                    col_d    = '0;
                    rowBad_d = 1'b0;
                end
            end

            COMMIT: begin
                if (frameBad_q) begin
                    frameErr_d = 1'b1;
                end else begin
                    rdBank_d    = ~rdBank_q;
                    frameDone_d = 1'b1;
                end
            end

            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q       <= '0;
            col_q       <= '0;
            sr_q        <= '0;
            rowBad_q    <= 1'b0;
            frameBad_q  <= 1'b0;
            rowOvf_q    <= 1'b0;
            wrEn_q      <= 1'b0;
            wrAddr_q    <= '0;
            wrData_q    <= '0;
            rdBank_q    <= 1'b0;
            frameDone_q <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            sr_q        <= sr_d;
            rowBad_q    <= rowBad_d;
            frameBad_q  <= frameBad_d;
            rowOvf_q    <= rowOvf_d;
            wrEn_q      <= wrEn_d;
            wrAddr_q    <= wrAddr_d;
            wrData_q    <= wrData_d;
            rdBank_q    <= rdBank_d;
            frameDone_q <= frameDone_d;
            frameErr_q  <= frameErr_d;
        end
    end

    assign wr_en      = wrEn_q;
    assign wr_addr    = wrAddr_q;
    assign wr_data    = wrData_q;
    assign rd_bank    = rdBank_q;
    assign frame_done = frameDone_q;
    assign frame_err  = frameErr_q;

endmodule

// File: tb/tb_dmd_capture.sv
// ---------------------------------------------------------------------------
// tb_dmd_capture
//
// Directed bench for dmd_capture. Rows keep the full 128-dot width; the
// frame height is set to 20 rows so the whole sequence stays short.
// Dot pattern: byte = row ^ byte_col, sent leftmost dot first.
// ---------------------------------------------------------------------------
module tb_dmd_capture;

    localparam int COLS        = 128;
    localparam int ROWS        = 20;
    localparam int SYNC_STAGES = 2;
    localparam int CW          = $clog2(COLS / 8);
    localparam int RW          = $clog2(ROWS);
    localparam int AW          = 1 + RW + CW;

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b0;
    logic          dmd_dotclk  = 1'b0;
    logic          dmd_data    = 1'b0;
    logic          dmd_rowclk  = 1'b0;
    logic          dmd_rowdata = 1'b0;
    logic          dmd_latch   = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          rd_bank;
    logic          frame_done;
    logic          frame_err;

    int checkCount = 0;
    int errorCount = 0;
    int doneCount  = 0;
    int errCount   = 0;
    logic expRd    = 1'b0;

    logic [AW+7:0] expQ [$];
    logic [AW+7:0] logQ [$];

    always #5 clk = ~clk;

    dmd_capture #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dmd_dotclk (dmd_dotclk),
        .dmd_data   (dmd_data),
        .dmd_rowclk (dmd_rowclk),
        .dmd_rowdata(dmd_rowdata),
        .dmd_latch  (dmd_latch),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_bank    (rd_bank),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    // Record every RAM write and count the frame status pulses.
    always @(negedge clk) begin
        if (wr_en) logQ.push_back({wr_addr, wr_data});
        if (frame_done) doneCount++;
        if (frame_err) errCount++;
    end

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic dotCycle(input logic d);
        dmd_dotclk = 1'b0;
        dmd_data   = d;
        waitCycles(2);
        dmd_dotclk = 1'b1;
        waitCycles(2);
    endtask

    task automatic rowStrobe(input logic first);
        dmd_rowdata = first;
        waitCycles(2);
        dmd_rowclk = 1'b1;
        waitCycles(2);
        dmd_rowclk = 1'b0;
        waitCycles(2);
    endtask

    task automatic latchStrobe();
        dmd_latch = 1'b1;
        waitCycles(2);
        dmd_latch = 1'b0;
        waitCycles(2);
    endtask

    // Expected write of one completed byte into the current write bank.
    task automatic expectByte(input int row, input int b);
        logic [7:0]    pat;
        logic [RW-1:0] rowBits;
        logic [CW-1:0] colBits;
        pat     = 8'(row ^ b);
        rowBits = RW'(row);
        colBits = CW'(b);
        expQ.push_back({~expRd, rowBits, colBits, pat});
    endtask

    // Dots of one row, pattern byte row ^ byte_col, leftmost dot first.
    task automatic sendDots(input int row, input int nDots, input logic expectWrites);
        logic [7:0] pat;
        for (int k = 0; k < nDots; k++) begin
            pat = 8'(row ^ (k / 8));
            dotCycle(pat[7 - (k % 8)]);
            if (expectWrites && (k % 8 == 7) && (k / 8 < COLS / 8)) expectByte(row, k / 8);
        end
    endtask

    // One row: rowclk strobe, nDots dots, latch.
    task automatic applyStimulus(input int row, input int nDots, input logic first,
                                 input logic expectWrites);
        rowStrobe(first);
        sendDots(row, nDots, expectWrites);
        latchStrobe();
    endtask

    task automatic compareWrites(input string tag);
        int n;
        checkOutput({tag, "_count"}, logQ.size(), expQ.size());
        n = (logQ.size() < expQ.size()) ? logQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_wr%0d", tag, i), 32'(logQ[i]), 32'(expQ[i]));
        end
        logQ.delete();
        expQ.delete();
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_wr_en"},      wr_en,      0);
        checkOutput({tag, "_wr_addr"},    wr_addr,    0);
        checkOutput({tag, "_wr_data"},    wr_data,    0);
        checkOutput({tag, "_rd_bank"},    rd_bank,    0);
        checkOutput({tag, "_frame_done"}, frame_done, 0);
        checkOutput({tag, "_frame_err"},  frame_err,  0);
    endtask

    initial begin
        // Reset values.
        waitCycles(3);
        checkIdleOutputs("reset");
        rst_n = 1'b1;
        waitCycles(3);

        // Before a first-row marker everything is ignored.
        applyStimulus(0, 16, 1'b0, 1'b0);
        waitCycles(8);
        compareWrites("presync");
        checkOutput("presync_done", doneCount, 0);
        checkOutput("presync_err",  errCount,  0);

        // Frame 1: good, written to bank 1, swap 0 -> 1.
        for (int r = 0; r < ROWS; r++) applyStimulus(r, COLS, r == 0, 1'b1);
        waitCycles(8);
        compareWrites("f1");
        checkOutput("f1_done", doneCount, 1);
        checkOutput("f1_err",  errCount,  0);
        checkOutput("f1_bank", rd_bank,   1);
        expRd = 1'b1;

        // Frame 2: identical, written to bank 0, swap 1 -> 0.
        for (int r = 0; r < ROWS; r++) applyStimulus(r, COLS, r == 0, 1'b1);
        waitCycles(8);
        compareWrites("f2");
        checkOutput("f2_done", doneCount, 2);
        checkOutput("f2_err",  errCount,  0);
        checkOutput("f2_bank", rd_bank,   0);
        expRd = 1'b0;

        // Frame 3: row 5 latched after 120 dots -> dropped.
        for (int r = 0; r < ROWS; r++) applyStimulus(r, (r == 5) ? 120 : COLS, r == 0, 1'b1);
        waitCycles(8);
        compareWrites("short");
        checkOutput("short_done", doneCount, 2);
        checkOutput("short_err",  errCount,  1);
        checkOutput("short_bank", rd_bank,   0);

        // Frame 4: row 9 carries 136 dots -> only 16 writes, dropped.
        for (int r = 0; r < ROWS; r++) applyStimulus(r, (r == 9) ? 136 : COLS, r == 0, 1'b1);
        waitCycles(8);
        compareWrites("long");
        checkOutput("long_done", doneCount, 2);
        checkOutput("long_err",  errCount,  2);
        checkOutput("long_bank", rd_bank,   0);

        // Premature first-row marker at row 17, then a complete frame.
        for (int r = 0; r < 17; r++) applyStimulus(r, COLS, r == 0, 1'b1);
        checkOutput("pre_err_before", errCount, 2);
        applyStimulus(0, COLS, 1'b1, 1'b1);
        checkOutput("pre_err_pulse", errCount, 3);
        for (int r = 1; r < ROWS; r++) applyStimulus(r, COLS, 1'b0, 1'b1);
        waitCycles(8);
        compareWrites("pre");
        checkOutput("pre_done", doneCount, 3);
        checkOutput("pre_err",  errCount,  3);
        checkOutput("pre_bank", rd_bank,   1);
        expRd = 1'b1;

        // Reset in the middle of row 10 while a byte write is in flight.
        for (int r = 0; r < 10; r++) applyStimulus(r, COLS, r == 0, 1'b1);
        rowStrobe(1'b0);
        sendDots(10, 32, 1'b1);
        for (int k = 32; k < 40; k++) dotCycle(k[0]);
        @(posedge clk);
        #2;
        checkOutput("rst_wr_pending", wr_en, 1);
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("rst_now");
        waitCycles(3);
        rst_n = 1'b1;
        expRd = 1'b0;
        waitCycles(3);
        applyStimulus(11, COLS, 1'b0, 1'b0);
        waitCycles(8);
        compareWrites("rst");
        checkOutput("rst_done", doneCount, 3);
        checkOutput("rst_err",  errCount,  3);

        // Capture resumes with the next marked row, into bank 1.
        applyStimulus(0, COLS, 1'b1, 1'b1);
        waitCycles(8);
        compareWrites("resume");
        checkOutput("resume_bank", rd_bank,  0);
        checkOutput("resume_err",  errCount, 3);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
